// File: rtl/ram_bank_arbiter_if.sv
// Requester and RAM-side signals of ram_bank_arbiter grouped into one bundle.
// master = requesters plus RAM (environment side), slave = the arbiter.
interface ram_bank_arbiter_if #(
    parameter int NREQ = 2,
    parameter int AW   = 8,
    parameter int DW   = 8,
    parameter int BW   = 2
);
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    wr;
    logic [NREQ*AW-1:0] addr;
    logic [NREQ*DW-1:0] wdata;
    logic [NREQ*BW-1:0] bank;
    logic [NREQ-1:0]    ack;
    logic [DW-1:0]      rdata;
    logic               busy;
    logic [AW-1:0]      Address;
    logic [DW-1:0]      Data;
    logic               WE;
    logic               RE;
    logic               SB;
    logic [DW-1:0]      datao;

    modport master (
        output req, wr, addr, wdata, bank, datao,
        input  ack, rdata, busy, Address, Data, WE, RE, SB
    );

    modport slave (
        input  req, wr, addr, wdata, bank, datao,
        output ack, rdata, busy, Address, Data, WE, RE, SB
    );
endinterface

// File: rtl/ram_bank_arbiter.sv
// Round-robin arbiter sharing one banked RAM, inserting SetBank before accesses.
// Optional macro BANK_CACHE_EN: skip SetBank when the cached bank already matches.
module ram_bank_arbiter #(
    parameter int NREQ = 2,
    parameter int AW   = 8,
    parameter int DW   = 8,
    parameter int BW   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    ram_bank_arbiter_if.slave bus
);
    localparam int PW = (NREQ > 2) ? 2 : 1;

    typedef enum logic [2:0] {IDLE, BANK, BANK_W, ACC, ACC_W, DONE, RESP} state_t;

    state_t          r_state;
    state_t          w_next;
    logic [PW-1:0]   r_rrPtr;
    logic [PW-1:0]   r_grant;
    logic [PW-1:0]   w_grant;
    logic            w_found;
    logic            r_wr;
    logic [AW-1:0]   r_addr;
    logic [DW-1:0]   r_wdata;
    logic [BW-1:0]   r_bank;
    logic [AW-1:0]   r_address;
    logic [DW-1:0]   r_data;
    logic [DW-1:0]   r_rdata;
    logic            w_needSb;
    logic            w_reqWr;
    logic [AW-1:0]   w_reqAddr;
    logic [DW-1:0]   w_reqWdata;
    logic [BW-1:0]   w_reqBank;
    logic [AW-1:0]   w_accAddr;
    logic [DW-1:0]   w_accData;

    // First requesting index at or after the round-robin pointer wins.
    always_comb begin
        w_found = 1'b0;
        w_grant = r_rrPtr;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_found && bus.req[(int'(r_rrPtr) + k) % NREQ]) begin
                w_found = 1'b1;
                w_grant = PW'((int'(r_rrPtr) + k) % NREQ);
            end
        end
    end

    assign w_reqWr    = bus.wr[w_grant];
    assign w_reqAddr  = bus.addr[int'(w_grant)*AW +: AW];
    assign w_reqWdata = bus.wdata[int'(w_grant)*DW +: DW];
    assign w_reqBank  = bus.bank[int'(w_grant)*BW +: BW];

    // Going straight from IDLE to ACC, the latches are not loaded yet.
    assign w_accAddr = (r_state == IDLE) ? w_reqAddr  : r_addr;
    assign w_accData = (r_state == IDLE) ? w_reqWdata : r_wdata;

`ifdef BANK_CACHE_EN
    logic [BW-1:0] r_curBank;
    logic          r_bankValid;

    // The RAM's bank register survives reset, so the cache starts invalid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_curBank   <= '0;
            r_bankValid <= 1'b0;
        end else if (r_state == BANK) begin
            r_curBank   <= r_bank;
            r_bankValid <= 1'b1;
        end
    end

    assign w_needSb = !r_bankValid || (w_reqBank != r_curBank);
`else
    assign w_needSb = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (w_found) w_next = w_needSb ? BANK : ACC;
            BANK:    w_next = BANK_W;
            BANK_W:  w_next = ACC;
            ACC:     w_next = ACC_W;
            ACC_W:   w_next = DONE;
            DONE:    w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        bus.WE   = 1'b0;
        bus.RE   = 1'b0;
        bus.SB   = 1'b0;
        bus.ack  = '0;
        bus.busy = (r_state != IDLE);
        case (r_state)
            BANK: bus.SB = 1'b1;
            ACC: begin
                bus.WE = r_wr;
                bus.RE = !r_wr;
            end
            RESP:    bus.ack[r_grant] = 1'b1;
            default: ;
        endcase
    end

    // Address/Data are loaded on entry to BANK/ACC so they are valid with the strobe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rrPtr   <= '0;
            r_grant   <= '0;
            r_wr      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_bank    <= '0;
            r_address <= '0;
            r_data    <= '0;
            r_rdata   <= '0;
        end else begin
            if (r_state == IDLE && w_found) begin
                r_grant <= w_grant;
                r_rrPtr <= PW'((int'(w_grant) + 1) % NREQ);
                r_wr    <= w_reqWr;
                r_addr  <= w_reqAddr;
                r_wdata <= w_reqWdata;
                r_bank  <= w_reqBank;
            end
            if (w_next == BANK) begin
                r_data <= DW'(w_reqBank);
            end
            if (w_next == ACC) begin
                r_address <= w_accAddr;
                r_data    <= w_accData;
            end
            if (r_state == DONE && !r_wr) begin
                r_rdata <= bus.datao;
            end
        end
    end

    assign bus.Address = r_address;
    assign bus.Data    = r_data;
    assign bus.rdata   = r_rdata;

endmodule

// File: tb/tb_ram_bank_arbiter.sv
// Directed bench for ram_bank_arbiter with a banked RAM model and an event scoreboard.
// Expectations follow BANK_CACHE_EN the same way the design build does.
module tb_ram_bank_arbiter;
    typedef struct {
        int         kind;
        int         who;
        logic [7:0] addr;
        logic [7:0] data;
        int         cyc;
        bit         isRead;
        bit         drop;
    } ev_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int   checkCount = 0;
    int   passCount  = 0;
    int   failCount  = 0;
    ev_t  expQ[$];

    logic [7:0] refMem [4][256] = '{default: '0};
    logic [1:0] mBank  = 2'd0;
    bit         mValid = 1'b0;

    logic [7:0] ramMem [4][256] = '{default: '0};
    logic [1:0] ramBank = 2'd3;
    logic       rdStage = 1'b0;
    logic [7:0] rdVal   = 8'h00;

    ram_bank_arbiter_if #(.NREQ(2), .AW(8), .DW(8), .BW(2)) bus ();

    ram_bank_arbiter #(.NREQ(2), .AW(8), .DW(8), .BW(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // RAM model: bank register never reset, read data valid two cycles after RE.
    always @(posedge clk) begin
        rdStage <= bus.RE;
        rdVal   <= ramMem[ramBank][bus.Address];
        if (bus.SB) ramBank <= bus.Data[1:0];
        if (bus.WE) ramMem[ramBank][bus.Address] <= bus.Data;
        bus.datao <= rdStage ? rdVal : 8'hEE;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Push SB (if the bank model needs one), the access strobe and the ack.
    function automatic void pushOp(input int who, input bit isWr, input logic [7:0] a,
                                   input logic [7:0] d, input logic [1:0] b, input bit drop);
        bit  need;
        int  base;
        ev_t e;
`ifdef BANK_CACHE_EN
        need = !mValid || (b != mBank);
`else
        need = 1'b1;
`endif
        base = need ? 2 : 0;
        if (need) begin
            e = '{kind: 0, who: who, addr: 8'h00, data: {6'b0, b}, cyc: 2, isRead: 1'b0, drop: 1'b0};
            expQ.push_back(e);
            mBank  = b;
            mValid = 1'b1;
        end
        e = '{kind: isWr ? 1 : 2, who: who, addr: a, data: d, cyc: base + 2, isRead: 1'b0, drop: 1'b0};
        expQ.push_back(e);
        if (isWr) refMem[b][a] = d;
        e = '{kind: 3, who: who, addr: a, data: isWr ? 8'h00 : refMem[b][a],
              cyc: base + 5, isRead: !isWr, drop: drop};
        expQ.push_back(e);
    endfunction

    task automatic applyStimulus(input int who, input bit isWr, input logic [7:0] a,
                                 input logic [7:0] d, input logic [1:0] b);
        bus.wr[who]            = isWr;
        bus.addr[who*8 +: 8]   = a;
        bus.wdata[who*8 +: 8]  = d;
        bus.bank[who*2 +: 2]   = b;
        bus.req[who]           = 1'b1;
    endtask

    // Cycle 1 is the IDLE cycle in which the request is seen.
    task automatic runUntilAcks(input int n);
        int         c      = 1;
        int         got    = 0;
        int         budget = 0;
        ev_t        e;
        logic [2:0] expStrobe;
        logic [1:0] expAck;
        while (got < n && budget < 40 * n) begin
            @(posedge clk);
            @(negedge clk);
            c++;
            budget++;
            if (bus.WE || bus.RE || bus.SB) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_strobe", {29'b0, bus.WE, bus.RE, bus.SB}, 32'h0);
                end else begin
                    e = expQ.pop_front();
                    expStrobe = (e.kind == 0) ? 3'b001 : (e.kind == 1) ? 3'b100 :
                                (e.kind == 2) ? 3'b010 : 3'b000;
                    checkOutput("strobes", {29'b0, bus.WE, bus.RE, bus.SB}, {29'b0, expStrobe});
                    checkOutput("strobe_cycle", c, e.cyc);
                    if (e.kind != 2) checkOutput("ram_data", {24'b0, bus.Data}, {24'b0, e.data});
                    if (e.kind != 0) checkOutput("ram_addr", {24'b0, bus.Address}, {24'b0, e.addr});
                end
            end
            if (bus.ack != 2'b00) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_ack", {30'b0, bus.ack}, 32'h0);
                end else begin
                    e = expQ.pop_front();
                    expAck = (e.kind == 3) ? (2'b01 << e.who) : 2'b00;
                    checkOutput("ack", {30'b0, bus.ack}, {30'b0, expAck});
                    checkOutput("ack_cycle", c, e.cyc);
                    if (e.isRead) checkOutput("rdata", {24'b0, bus.rdata}, {24'b0, e.data});
                    if (e.drop) bus.req[e.who] = 1'b0;
                end
                c = 0;
                got++;
            end
        end
        if (got < n) begin
            checkCount++;
            failCount++;
            $error("[TB] FAIL ack_timeout: observed %0d acks expected %0d", got, n);
            bus.req = '0;
        end
        @(negedge clk);
        checkOutput("idle_busy", {31'b0, bus.busy}, 32'h0);
        checkOutput("queue_drained", expQ.size(), 0);
    endtask

    initial begin
        bit seen;
        bus.req   = '0;
        bus.wr    = '0;
        bus.addr  = '0;
        bus.wdata = '0;
        bus.bank  = '0;
        repeat (3) @(negedge clk);
        $display("[TB] reset state");
        checkOutput("rst_busy", {31'b0, bus.busy}, 32'h0);
        checkOutput("rst_ack", {30'b0, bus.ack}, 32'h0);
        checkOutput("rst_strobes", {29'b0, bus.WE, bus.RE, bus.SB}, 32'h0);
        checkOutput("rst_address", {24'b0, bus.Address}, 32'h0);
        checkOutput("rst_data", {24'b0, bus.Data}, 32'h0);
        checkOutput("rst_rdata", {24'b0, bus.rdata}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] write 0xA5 to bank 1 addr 0x10");
        pushOp(0, 1'b1, 8'h10, 8'hA5, 2'd1, 1'b1);
        applyStimulus(0, 1'b1, 8'h10, 8'hA5, 2'd1);
        runUntilAcks(1);

        $display("[TB] read back bank 1 addr 0x10");
        pushOp(0, 1'b0, 8'h10, 8'h00, 2'd1, 1'b1);
        applyStimulus(0, 1'b0, 8'h10, 8'h00, 2'd1);
        runUntilAcks(1);

        $display("[TB] requester 1 writes bank 2");
        pushOp(1, 1'b1, 8'h30, 8'h3C, 2'd2, 1'b1);
        applyStimulus(1, 1'b1, 8'h30, 8'h3C, 2'd2);
        runUntilAcks(1);

        $display("[TB] round robin with both requests held");
        pushOp(0, 1'b0, 8'h10, 8'h00, 2'd1, 1'b0);
        pushOp(1, 1'b0, 8'h30, 8'h00, 2'd2, 1'b0);
        pushOp(0, 1'b0, 8'h10, 8'h00, 2'd1, 1'b1);
        pushOp(1, 1'b0, 8'h30, 8'h00, 2'd2, 1'b1);
        applyStimulus(0, 1'b0, 8'h10, 8'h00, 2'd1);
        applyStimulus(1, 1'b0, 8'h30, 8'h00, 2'd2);
        runUntilAcks(4);

        $display("[TB] reset during ACC_W");
        applyStimulus(0, 1'b0, 8'h10, 8'h00, 2'd1);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.RE) seen = 1'b1;
        end
        checkOutput("abort_re_seen", {31'b0, seen}, 32'h1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        bus.req = '0;
        checkOutput("abort_strobes", {29'b0, bus.WE, bus.RE, bus.SB}, 32'h0);
        checkOutput("abort_ack", {30'b0, bus.ack}, 32'h0);
        checkOutput("abort_busy", {31'b0, bus.busy}, 32'h0);
        checkOutput("abort_address", {24'b0, bus.Address}, 32'h0);
        @(negedge clk);
        checkOutput("abort_ack_later", {30'b0, bus.ack}, 32'h0);
        rst_n  = 1'b1;
        mValid = 1'b0;
        @(negedge clk);

        $display("[TB] bank 0 access after reset");
        pushOp(0, 1'b0, 8'h20, 8'h00, 2'd0, 1'b1);
        applyStimulus(0, 1'b0, 8'h20, 8'h00, 2'd0);
        runUntilAcks(1);
        pushOp(1, 1'b1, 8'h20, 8'h5A, 2'd0, 1'b1);
        applyStimulus(1, 1'b1, 8'h20, 8'h5A, 2'd0);
        runUntilAcks(1);
        pushOp(0, 1'b0, 8'h20, 8'h00, 2'd0, 1'b1);
        applyStimulus(0, 1'b0, 8'h20, 8'h00, 2'd0);
        runUntilAcks(1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule

// File: doc/ram_bank_arbiter.md
Name: ram_bank_arbiter

Overview:
- Shares one banked 8-bit RAM between NREQ requesters using round-robin arbitration.
- Converts each granted request into the RAM's single-cycle strobe protocol (WE, RE, SB).
- Inserts a SetBank command automatically when the requester's bank differs from the bank currently selected in the RAM.
- Returns read data and a one-cycle ack to the granted requester.

Parameters:
- NREQ, 2, number of requesters (2..4).
- AW, 8, address width.
- DW, 8, data width.
- BW, 2, bank-select width.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- req  in  NREQ  per-requester request; held high until that requester's ack.
- wr  in  NREQ  per-requester op: 1 = write, 0 = read; stable while req is high.
- addr  in  NREQ*AW  packed addresses; requester i uses bits [i*AW +: AW].
- wdata  in  NREQ*DW  packed write data.
- bank  in  NREQ*BW  packed bank selects.
- ack  out  NREQ  one-hot, one-cycle completion pulse.
- rdata  out  DW  read data, valid in the cycle ack is high for a read.
- busy  out  1  high whenever the FSM is not in IDLE.
- Address  out  AW  RAM address.
- Data  out  DW  RAM data; carries wdata for WE, and the bank in bits [BW-1:0] (zero-extended) for SB.
- WE  out  1  RAM write strobe.
- RE  out  1  RAM read strobe.
- SB  out  1  RAM set-bank strobe.
- datao  in  DW  RAM read data.

Behaviour:
- RAM contract:
  - Exactly one of WE/RE/SB is high, for exactly one cycle (cycle 0).
  - The RAM is busy in cycle 1.
  - The RAM accepts a new strobe no earlier than cycle 2.
  - For RE, datao is valid in cycle 2.
- Reset (rst_n = 0 at a clk edge) forces:
  - State IDLE; WE = RE = SB = 0; ack = 0; busy = 0.
  - rdata = 0, Address = 0, Data = 0.
  - rr_ptr = 0, cur_bank = 0, bank_valid = 0.
- Reset mid-operation:
  - Abandons the transaction with no ack.
  - Strobes go low in the first reset cycle.
  - bank_valid = 0 forces an SB before the next access, because the RAM's bank register is not reset.
- Arbitration (in IDLE, when any req is high):
  - Grant the first requester with req high, searching from rr_ptr upward modulo NREQ.
  - Latch that requester's wr, addr, wdata and bank into internal registers.
  - Set rr_ptr to (grant + 1) mod NREQ.
  - Requests arriving during a transaction wait; there is no preemption.
- FSM states, one cycle each unless noted:
  - IDLE: no req → stay. Grant with need_sb → BANK. Grant without need_sb → ACC.
  - BANK: SB = 1; Data = bank zero-extended; cur_bank <= bank; bank_valid <= 1; → BANK_W.
  - BANK_W: all strobes low → ACC.
  - ACC: WE = wr or RE = !wr; Address/Data driven from the latched values → ACC_W.
  - ACC_W: strobes low → DONE.
  - DONE: rdata <= datao if the op is a read, otherwise rdata is held; → RESP.
  - RESP: ack[grant] = 1 → IDLE. The requester may drop req, or keep it high to request again; the new request is arbitrated normally.
- need_sb = !bank_valid OR (bank != cur_bank).
  - In the build without BANK_CACHE_EN, need_sb = 1 for every access.
- Latency from grant edge to ack: 5 cycles without SB, 7 cycles with SB.
- Back-to-back: the next grant is evaluated in IDLE, the cycle after RESP.
- Address and Data hold their last driven values while strobes are low.

Optional Feature:
- Macro BANK_CACHE_EN.
- Defined: the arbiter tracks cur_bank/bank_valid and skips SB when the requested bank matches the cached bank.
- Undefined: every access is preceded by BANK/BANK_W. cur_bank/bank_valid are not implemented, and the fixed latency is 7 cycles.

Test Plan:
- Reset, then req[0] = 1, wr = 1, addr = 0x10, wdata = 0xA5, bank = 1:
  - SB pulse with Data = 0x01.
  - Two cycles later, WE pulse with Address = 0x10, Data = 0xA5.
  - ack[0] 7 cycles after grant.
- Then req[0] read, addr = 0x10, bank = 1 (BANK_CACHE_EN defined):
  - No SB; RE pulse.
  - ack[0] after 5 cycles with rdata = 0xA5.
- req[0] and req[1] high continuously, rr_ptr = 0:
  - Grants alternate 0, 1, 0, 1.
  - ack never high on two bits at once.
- req[1] write, bank = 2, while cur_bank = 1:
  - SB with Data = 0x02 precedes WE.
  - Reading back bank 1, addr 0x10, still returns 0xA5.
- Assert rst_n = 0 during ACC_W:
  - No ack; strobes low.
  - The next request issues SB even for bank 0.
- Build without BANK_CACHE_EN:
  - Every access shows SB, then WE/RE.
  - Latency is always 7 cycles.
